// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among N_REQ requesters.
// Supports locked bursts of up to MAX_BURST grants. Each response arrives one cycle after its grant.
//
// state  | meaning
// ARB    | round-robin search starting at ptr_q
// LOCKED | only owner_q may be granted; burst_cnt_q counts its transfers
module sprite_rom_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 3,
    parameter int MAX_BURST = 8
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic                      frame_start,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               block_q, block_d;
    logic [PTR_W-1:0]   block_idx_q, block_idx_d;
    logic [N_REQ-1:0]   rsp_valid_q;

    logic               gnt_vld;
    logic [PTR_W-1:0]   gnt_idx;
    logic [N_REQ-1:0]   gnt_oh;
    logic [N_REQ-1:0]   block_oh;
    logic [N_REQ-1:0]   elig;
    logic [PTR_W-1:0]   cand;
    int                 j;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(N_REQ - 1)) return '0;
        else return p + 1'b1;
    endfunction

    // After a burst hits MAX_BURST the old owner is masked for one cycle unless it is the only requester.
    always_comb begin
        block_oh = '0;
        if (block_q) block_oh[block_idx_q] = 1'b1;
        elig = req_valid;
        if (|(req_valid & ~block_oh)) elig = req_valid & ~block_oh;
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        cand    = '0;
        if (reset_n) begin
            if (state_q == LOCKED) begin
                if (req_valid[owner_q]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = owner_q;
                end
            end else begin
                // Scan from the far end back so the candidate nearest ptr_q wins.
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    j = int'(ptr_q) + k;
                    if (j >= N_REQ) j = j - N_REQ;
                    cand = PTR_W'(j);
                    if (elig[cand]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    end

    assign req_ready   = gnt_oh;
    assign rom_address = gnt_vld ? req_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rom_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        block_d     = 1'b0;
        block_idx_d = block_idx_q;
        case (state_q)
            ARB: begin
                if (gnt_vld) begin
                    if (req_lock[gnt_idx] && (MAX_BURST > 1)) begin
                        state_d     = LOCKED;
                        owner_d     = gnt_idx;
                        burst_cnt_d = CNT_W'(1);
                    end else begin
                        ptr_d = ptr_inc(gnt_idx);
                        // A one-grant burst is already exhausted.
                        if (req_lock[gnt_idx]) begin
                            block_d     = 1'b1;
                            block_idx_d = gnt_idx;
                        end
                    end
                end
            end
            LOCKED: begin
                if (!req_lock[owner_q]) begin
                    state_d     = ARB;
                    ptr_d       = ptr_inc(owner_q);
                    burst_cnt_d = '0;
                end else if (gnt_vld) begin
                    if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d     = ARB;
                        ptr_d       = ptr_inc(owner_q);
                        burst_cnt_d = '0;
                        block_d     = 1'b1;
                        block_idx_d = owner_q;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
        if (frame_start) begin
            state_d     = ARB;
            ptr_d       = '0;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            block_q     <= 1'b0;
            block_idx_q <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            block_q     <= block_d;
            block_idx_q <= block_idx_d;
            rsp_valid_q <= gnt_oh;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin / burst-lock model.
module tb_sprite_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 3;
    localparam int MB = 8;

    logic            vga_clk = 1'b0;
    logic            reset_n;
    logic            frame_start;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   rom_address;
    logic [DW-1:0]   rom_q;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;

    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .req_valid   (req_valid),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data)
    );

    logic [DW-1:0] rom_mem [0:(1<<AW)-1];
    always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit            m_locked;
    int            m_owner, m_cnt, m_ptr, m_block;
    logic [N-1:0]  m_prev_gnt;
    logic [AW-1:0] m_prev_addr;

    logic [N-1:0]  last_ready, last_rsp;
    logic [AW-1:0] last_addr;
    logic [N-1:0]  one = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        bit others = 0;
        int jj;
        if (!reset_n) return -1;
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int i = 0; i < N; i++)
            if (req_valid[i] && i != m_block) others = 1;
        for (int k = 0; k < N; k++) begin
            jj = (m_ptr + k) % N;
            if (req_valid[jj] && !(jj == m_block && others)) return jj;
        end
        return -1;
    endfunction

    task automatic model_update(input int g, input logic [AW-1:0] ga);
        int nb = -1;
        if (!reset_n) begin
            m_locked = 0; m_ptr = 0; m_cnt = 0; m_owner = 0; m_block = -1;
            m_prev_gnt = '0;
            return;
        end
        if (m_locked) begin
            if (!req_lock[m_owner]) begin
                m_locked = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
            end else if (g >= 0) begin
                m_cnt++;
                if (m_cnt == MB) begin
                    m_locked = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0; nb = m_owner;
                end
            end
        end else if (g >= 0) begin
            if (req_lock[g] && MB > 1) begin
                m_locked = 1; m_owner = g; m_cnt = 1;
            end else begin
                m_ptr = (g + 1) % N;
                if (req_lock[g]) nb = g;
            end
        end
        m_block = nb;
        if (frame_start) begin
            m_locked = 0; m_ptr = 0; m_cnt = 0;
        end
        m_prev_gnt  = (g >= 0) ? (one << g) : '0;
        m_prev_addr = ga;
    endtask

    task automatic step(input logic fs, input logic rn, input logic [N-1:0] v, input logic [N-1:0] l);
        int            g;
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        frame_start = fs;
        reset_n     = rn;
        req_valid   = v;
        req_lock    = l;
        #1;
        g  = model_grant();
        eg = (g >= 0) ? (one << g) : '0;
        ea = (g >= 0) ? req_addr[g*AW +: AW] : '0;
        check("req_ready", 32'(req_ready), 32'(eg));
        check("rom_address", 32'(rom_address), 32'(ea));
        check("rsp_valid", 32'(rsp_valid), 32'(m_prev_gnt));
        if (m_prev_gnt != '0)
            check("rsp_data", 32'(rsp_data), 32'(rom_mem[m_prev_addr]));
        check("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
        last_ready = req_ready;
        last_addr  = rom_address;
        last_rsp   = rsp_valid;
        model_update(g, ea);
        @(negedge vga_clk);
    endtask

    task automatic rand_addr();
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) rom_mem[i] = DW'($urandom);
        reset_n = 1'b0; frame_start = 1'b0; req_valid = '0; req_lock = '0;
        rand_addr();
        m_locked = 0; m_ptr = 0; m_cnt = 0; m_owner = 0; m_block = -1;
        m_prev_gnt = '0; m_prev_addr = '0;
        @(negedge vga_clk);
        @(negedge vga_clk);

        // reset holds grants off even with requests present
        step(0, 0, 4'hF, 4'h0);
        check("reset_ready", 32'(last_ready), 32'd0);

        // plain round robin
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 4'hF, 4'h0);
            check("rr_seq", 32'(last_ready), 32'(one << (k % 4)));
        end

        // single requester at a fixed address
        req_addr[2*AW +: AW] = 10'h05A;
        step(0, 1, 4'b0100, 4'h0);
        check("single_ready", 32'(last_ready), 32'(4'b0100));
        check("single_addr", 32'(last_addr), 32'(10'h05A));
        step(0, 1, 4'h0, 4'h0);
        check("single_rsp", 32'(last_rsp), 32'(4'b0100));

        // reseed ptr, then requester 1 locks for a full burst
        step(1, 1, 4'h0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 4'hF, 4'b0010);
            check("burst1", 32'(last_ready),
                  (k == 0) ? 32'(4'b0001) : (k == 9) ? 32'(4'b0100) : 32'(4'b0010));
        end

        // requester 3 locks, goes idle for two cycles mid-burst
        step(0, 1, 4'hF, 4'b1000);
        check("burst3_start", 32'(last_ready), 32'(4'b1000));
        for (int k = 0; k < 2; k++) step(0, 1, 4'hF, 4'b1000);
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 4'b0111, 4'b1000);
            check("burst3_gap", 32'(last_ready), 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 4'hF, 4'b1000);
            check("burst3_resume", 32'(last_ready), 32'(4'b1000));
        end
        step(0, 1, 4'hF, 4'b1000);
        check("burst3_exit", 32'(last_ready), 32'(4'b0001));

        // frame_start while requester 2 holds a lock
        step(0, 1, 4'b0100, 4'b0100);
        step(1, 1, 4'hF, 4'b0100);
        check("fs_locked_grant", 32'(last_ready), 32'(4'b0100));
        step(0, 1, 4'hF, 4'h0);
        check("fs_regrant", 32'(last_ready), 32'(4'b0001));

        // reset right after a grant
        step(0, 1, 4'hF, 4'h0);
        step(0, 0, 4'hF, 4'h0);
        check("rst_ready0", 32'(last_ready), 32'd0);
        step(0, 0, 4'hF, 4'h0);
        check("rst_rsp_dropped", 32'(last_rsp), 32'd0);
        step(0, 1, 4'hF, 4'h0);
        check("post_rst_grant", 32'(last_ready), 32'(4'b0001));

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            rand_addr();
            step(($urandom % 40) == 0, ($urandom % 90) != 0,
                 N'($urandom), ($urandom % 2) ? N'($urandom) : '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter ADDR_W, default 10, sprite ROM address width.
REQ-003 Parameter DATA_W, default 3, ROM word (palette index) width.
REQ-004 Parameter MAX_BURST, default 8, maximum consecutive grants to one locked requester (1..255).
REQ-005 vga_clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 frame_start  in  1  one-cycle pulse at start of frame; re-seeds arbitration.
REQ-008 req_valid  in  N_REQ  per-requester read request.
REQ-009 req_lock  in  N_REQ  per-requester burst hold request.
REQ-010 req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-011 req_ready  out  N_REQ  one-hot-or-zero grant, combinational, this cycle.
REQ-012 rom_address  out  ADDR_W  address to synchronous ROM (1-cycle read latency).
REQ-013 rom_q  in  DATA_W  ROM data, valid the cycle after address is sampled.
REQ-014 rsp_valid  out  N_REQ  one-hot-or-zero; marks owner of rsp_data this cycle.
REQ-015 rsp_data  out  DATA_W  equals rom_q; shared by all requesters.

Function
REQ-016 Handshake: transfer for requester i occurs in cycle t when req_valid[i] and req_ready[i] are both 1.
REQ-017 At most one req_ready bit SHALL be 1 per cycle; req_ready[i] SHALL never be 1 while req_valid[i] is 0.
REQ-018 rom_address SHALL equal req_addr of the granted requester in the grant cycle, and all zeros when no grant.
REQ-019 rsp_valid[i] SHALL be 1 in cycle t+1 exactly when requester i transferred in cycle t; latency fixed at 1 cycle, throughput 1 transfer/cycle.
REQ-020 Round-robin: pointer ptr (0..N_REQ-1); grant goes to first valid requester searching ptr, ptr+1, ... modulo N_REQ.
REQ-021 After a non-locked grant to i, ptr SHALL become (i+1) mod N_REQ; with no grant, ptr holds.
REQ-022 FSM states ARB and LOCKED; reset state ARB.
REQ-023 ARB -> LOCKED when grant to i with req_lock[i]=1; owner:=i, burst_cnt:=1, ptr unchanged.
REQ-024 In LOCKED, only owner may be granted; grant when req_valid[owner]=1, burst_cnt increments per transfer; owner idle cycles grant nobody.
REQ-025 LOCKED -> ARB with ptr:=(owner+1) mod N_REQ when req_lock[owner]=0 or burst_cnt reaches MAX_BURST after a transfer; the cycle of the MAX_BURST-th transfer is still granted to owner.
REQ-026 A LOCKED exit caused by MAX_BURST SHALL not re-lock the same owner on the immediately following cycle unless no other requester is valid.
REQ-027 frame_start=1: state:=ARB, ptr:=0, burst_cnt:=0 at the clock edge; arbitration in that same cycle uses pre-pulse state; in-flight rsp_valid still delivered.
REQ-028 burst_cnt width ceil(log2(MAX_BURST+1)); SHALL never wrap.
REQ-029 Requester deasserting req_valid without handshake SHALL lose no state; no response is generated.

Reset
REQ-030 While reset_n=0 at a clock edge: state:=ARB, ptr:=0, burst_cnt:=0, owner:=0, rsp_valid:=0.
REQ-031 During reset cycles req_ready SHALL be all zeros and rom_address all zeros.
REQ-032 Reset mid-burst or with a response pending SHALL discard the pending response; rsp_valid=0 the cycle after reset is sampled.
REQ-033 reset_n has priority over frame_start.

Verification
REQ-034 Reset, then req_valid=4'b1111, no lock, for 8 cycles -> grants 0,1,2,3,0,1,2,3; each rsp_valid one cycle later with rsp_data = ROM contents of that requester's address.
REQ-035 req_valid=4'b0100 only, addr 10'h05A -> req_ready=4'b0100, rom_address=10'h05A same cycle; rsp_valid=4'b0100 next cycle.
REQ-036 Requester 1 locked, all valid, MAX_BURST=8 -> 8 consecutive grants to 1, then grant to 2, ptr=3.
REQ-037 Requester 3 locked, drops req_valid for 2 cycles mid-burst -> no grants those cycles, burst resumes, burst_cnt unchanged across gap.
REQ-038 frame_start pulsed while ptr=2 and LOCKED owner=2 -> next cycle state ARB, grant to requester 0 when all valid.
REQ-039 reset_n=0 asserted the cycle after a grant -> rsp_valid=0 next cycle, req_ready=0 throughout reset, first post-reset grant to requester 0.
